// File: rtl/io_tx_buffer.sv
// io_tx_buffer
//   Output-side MMIO block on the cpu memory bus. Non-zero byte writes to
//   0x30000 are queued in a first-word-fall-through FIFO that drains to the
//   UART transmitter. A write to 0x30004 requests a program stop. The stop
//   pulse is issued only once every queued byte has left the FIFO.
//
//   Handshake (tx side): a byte transfers on any cycle where tx_valid and
//   tx_ready are both high. tx_valid/tx_data come straight from registers and
//   never depend on tx_ready. tx_data is held stable while tx_valid is high
//   and tx_ready is low.
//
// Ports
//   clk_in          system clock
//   rst_in          asynchronous, active-high reset
//   rdy_in          cpu ready; bus decode is disabled while low
//   mem_a[31:0]     cpu address; only [17:0] is decoded
//   mem_dout[7:0]   cpu write data
//   mem_wr          1 = write
//   io_buffer_full  registered back-pressure to the cpu
//   tx_data[7:0]    byte offered to the UART
//   tx_valid        tx_data is valid
//   tx_ready        UART accepts the byte this cycle
//   program_stop    one-cycle pulse: stop requested and all output drained
//   overflow        sticky: a byte was dropped because the FIFO was full
//
// Optional build macro IO_TX_STATS_EN adds:
//   tx_byte_cnt[31:0]  bytes popped, wraps at 2^32
//   drop_cnt[15:0]     bytes dropped on a full FIFO, saturates at 16'hFFFF

module io_tx_buffer #(
  parameter int FIFO_WIDTH = 3,
  parameter int FULL_SLACK = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        program_stop,
`ifdef IO_TX_STATS_EN
  output logic [31:0] tx_byte_cnt,
  output logic [15:0] drop_cnt,
`endif
  output logic        overflow
);

  localparam int CW = FIFO_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH      = CW'(1 << FIFO_WIDTH);
  localparam logic [CW-1:0] FULL_LEVEL = CW'((1 << FIFO_WIDTH) - FULL_SLACK);

  logic [7:0]            mem [1 << FIFO_WIDTH];
  logic [FIFO_WIDTH-1:0] head;
  logic [FIFO_WIDTH-1:0] tail;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_next;
  logic                  stop_pending;

  logic io_sel;
  logic push_req;
  logic stop_req;
  logic pop;
  logic push_ok;
  logic drop;
  logic stop_done;

  // Address bits outside the decoded set are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_a[31:18], mem_a[15:3]};

  // Bus decode
  assign io_sel   = rdy_in & mem_wr & (mem_a[17:16] == 2'b11);
  assign push_req = io_sel & (mem_a[2:0] == 3'b000) & (mem_dout != 8'h00);
  assign stop_req = io_sel & (mem_a[2:0] == 3'b100);

  // FWFT outputs, straight from registers
  assign tx_valid = (count != '0);
  assign tx_data  = mem[head];
  assign pop      = tx_valid & tx_ready;

  always_comb begin
    push_ok    = 1'b0;
    drop       = 1'b0;
    count_next = count;
    // Once a stop is pending the program is over: late data writes are
    // discarded silently rather than counted as overflow.
    if (push_req && !stop_pending) begin
      if (count != DEPTH || pop) begin
        push_ok = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
    count_next = count + CW'(push_ok) - CW'(pop);
    // Stop completes on the cycle the FIFO becomes (or already is) empty,
    // so the pulse appears the cycle after the last pop, or the cycle after
    // the stop write when nothing is queued. push_ok is 0 whenever a stop is
    // active, so count_next == 0 also guarantees no push this cycle.
    stop_done = (stop_pending | stop_req) & (count_next == '0);
  end

  // FIFO storage: not reset
  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      mem[tail] <= mem_dout;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      stop_pending   <= 1'b0;
      io_buffer_full <= 1'b0;
      program_stop   <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      count          <= count_next;
      io_buffer_full <= (count_next >= FULL_LEVEL);
      program_stop   <= stop_done;
      if (pop) begin
        head <= head + 1'b1;
      end
      if (push_ok) begin
        tail <= tail + 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      if (stop_done) begin
        stop_pending <= 1'b0;
      end else if (stop_req) begin
        stop_pending <= 1'b1;
      end
    end
  end

`ifdef IO_TX_STATS_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tx_byte_cnt <= '0;
      drop_cnt    <= '0;
    end else begin
      if (pop) begin
        tx_byte_cnt <= tx_byte_cnt + 32'd1;
      end
      if (drop && drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_io_tx_buffer.sv
// Testbench for io_tx_buffer: table of single-write decode vectors plus
// hand-written sequences for back-pressure, overflow, full+pop, stop drain,
// rdy_in gating and reset mid-operation. Delivered bytes are checked against
// an expected queue filled when writes are driven.

module tb_io_tx_buffer;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic [31:0] mem_a = '0;
  logic [7:0]  mem_dout = '0;
  logic        mem_wr = 1'b0;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        program_stop;
  logic        overflow;
`ifdef IO_TX_STATS_EN
  logic [31:0] tx_byte_cnt;
  logic [15:0] drop_cnt;
`endif

  io_tx_buffer dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .program_stop   (program_stop),
`ifdef IO_TX_STATS_EN
    .tx_byte_cnt    (tx_byte_cnt),
    .drop_cnt       (drop_cnt),
`endif
    .overflow       (overflow)
  );

  // clock
  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  int cyc          = 0;
  int last_pop_cyc = -1;
  int stop_cyc     = -1;
  int stop_seen    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard: compare every transferred byte against the expected queue
  always @(negedge clk_in) begin
    cyc++;
    if (!rst_in) begin
      if (tx_valid && tx_ready) begin
        last_pop_cyc = cyc;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tx_unexpected: got byte 0x%0h expected no transfer (t=%0t)", tx_data, $time);
        end else begin
          check("tx_data", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
        end
      end
      if (program_stop) begin
        stop_seen++;
        stop_cyc = cyc;
      end
    end
  end

  // drivers
  task automatic do_reset();
    rst_in = 1'b1;
    mem_wr = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_full", {31'h0, io_buffer_full}, 32'h0);
    check("rst_stop", {31'h0, program_stop}, 32'h0);
    check("rst_overflow", {31'h0, overflow}, 32'h0);
    rst_in = 1'b0;
    stop_seen = 0;
  endtask

  // one bus write lasting exactly one cycle; returns 1 time unit after the edge
  task automatic bus_write(input logic [31:0] addr, input logic [7:0] data);
    mem_a    = addr;
    mem_dout = data;
    mem_wr   = 1'b1;
    @(posedge clk_in);
    #1;
    mem_wr   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  data;
    logic        rdy;
    logic        exp_push;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{1'b1, 32'h0003_0000, 8'h41, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 32'h0003_0000, 8'h00, 1'b1, 1'b0}; // zero filtered
    vecs[2] = '{1'b1, 32'h0000_0100, 8'h55, 1'b1, 1'b0}; // other address
    vecs[3] = '{1'b0, 32'h0003_0000, 8'h66, 1'b1, 1'b0}; // read
    vecs[4] = '{1'b1, 32'h0003_0000, 8'h12, 1'b0, 1'b0}; // cpu not ready
    vecs[5] = '{1'b1, 32'h0007_0000, 8'h5A, 1'b1, 1'b1}; // bit 18 not decoded
    vecs[6] = '{1'b1, 32'h0003_0008, 8'h23, 1'b1, 1'b1}; // bit 3 not decoded
    vecs[7] = '{1'b1, 32'h0003_0001, 8'h24, 1'b1, 1'b0}; // low bits mismatch

    do_reset();

    // single byte: exact FWFT timing
    tx_ready = 1'b1;
    exp_q.push_back(8'h41);
    bus_write(32'h0003_0000, 8'h41);
    check("single_valid", {31'h0, tx_valid}, 32'h1);
    check("single_data", {24'h0, tx_data}, 32'h41);
    idle(1);
    check("single_valid_drop", {31'h0, tx_valid}, 32'h0);

    // decode vector table
    for (int i = 0; i < 8; i++) begin
      rdy_in   = vecs[i].rdy;
      mem_a    = vecs[i].addr;
      mem_dout = vecs[i].data;
      mem_wr   = vecs[i].wr;
      if (vecs[i].exp_push) exp_q.push_back(vecs[i].data);
      @(posedge clk_in);
      #1;
      mem_wr = 1'b0;
      rdy_in = 1'b1;
      idle(3);
      check($sformatf("vec%0d_drained", i), exp_q.size(), 32'h0);
      check($sformatf("vec%0d_idle", i), {31'h0, tx_valid}, 32'h0);
    end
    check("decode_overflow", {31'h0, overflow}, 32'h0);

    // back-pressure and overflow
    do_reset();
    tx_ready = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (k <= 8) exp_q.push_back(8'(k));
      bus_write(32'h0003_0000, 8'(k));
      if (k == 5) check("full_at5", {31'h0, io_buffer_full}, 32'h0);
      if (k == 6) check("full_at6", {31'h0, io_buffer_full}, 32'h1);
      if (k == 8) check("ovf_at8", {31'h0, overflow}, 32'h0);
      if (k == 9) check("ovf_at9", {31'h0, overflow}, 32'h1);
    end
    tx_ready = 1'b1;
    idle(12);
    check("ovf_drained", exp_q.size(), 32'h0);
    check("ovf_full_clear", {31'h0, io_buffer_full}, 32'h0);
    check("ovf_sticky", {31'h0, overflow}, 32'h1);

    // full FIFO with simultaneous push and pop
    do_reset();
    tx_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(8'h10 + 8'(k));
      bus_write(32'h0003_0000, 8'h10 + 8'(k));
    end
    check("fullpop_full", {31'h0, io_buffer_full}, 32'h1);
    tx_ready = 1'b1;
    exp_q.push_back(8'h77);
    bus_write(32'h0003_0000, 8'h77);
    idle(12);
    check("fullpop_drained", exp_q.size(), 32'h0);
    check("fullpop_no_ovf", {31'h0, overflow}, 32'h0);

    // stop waits for drain; late push discarded
    do_reset();
    tx_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(8'hA1 + 8'(k));
      bus_write(32'h0003_0000, 8'hA1 + 8'(k));
    end
    bus_write(32'h0003_0004, 8'h00);
    bus_write(32'h0003_0000, 8'h42);
    idle(3);
    check("stop_held", stop_seen, 32'h0);
    tx_ready = 1'b1;
    idle(8);
    check("stop_drained", exp_q.size(), 32'h0);
    check("stop_once", stop_seen, 32'h1);
    check("stop_after_pop", stop_cyc, last_pop_cyc + 1);
    check("stop_no_ovf", {31'h0, overflow}, 32'h0);

    // stop with empty FIFO: latency 1, one-cycle pulse
    bus_write(32'h0003_0004, 8'h00);
    check("stop_empty_pulse", {31'h0, program_stop}, 32'h1);
    idle(1);
    check("stop_empty_clear", {31'h0, program_stop}, 32'h0);
    bus_write(32'h0003_0000, 8'h61);
    exp_q.push_back(8'h61);
    idle(3);
    check("push_after_stop", exp_q.size(), 32'h0);

    // rdy_in low: no decode, drain continues
    do_reset();
    tx_ready = 1'b0;
    exp_q.push_back(8'h51);
    bus_write(32'h0003_0000, 8'h51);
    exp_q.push_back(8'h52);
    bus_write(32'h0003_0000, 8'h52);
    rdy_in = 1'b0;
    bus_write(32'h0003_0000, 8'h33);
    bus_write(32'h0003_0004, 8'h00);
    tx_ready = 1'b1;
    idle(5);
    rdy_in = 1'b1;
    check("rdy_drained", exp_q.size(), 32'h0);
    check("rdy_idle", {31'h0, tx_valid}, 32'h0);
    check("rdy_no_stop", stop_seen, 32'h0);

    // reset mid-operation drops queued bytes and pending stop
    tx_ready = 1'b0;
    bus_write(32'h0003_0000, 8'h71);
    bus_write(32'h0003_0000, 8'h72);
    bus_write(32'h0003_0004, 8'h00);
    do_reset();
    tx_ready = 1'b1;
    idle(5);
    check("midrst_idle", {31'h0, tx_valid}, 32'h0);
    check("midrst_no_stop", stop_seen, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_tx_buffer.md
Name: io_tx_buffer

Overview:
Output-side MMIO block downstream of the cpu memory bus (mem_a / mem_dout / mem_wr). It decodes byte writes to 0x30000 and queues them in a FIFO that drains to the UART transmitter over a valid/ready handshake. It generates the io_buffer_full back-pressure signal consumed by the cpu. It also turns a write to 0x30004 into a program-stop pulse, issued only after every queued byte has drained.

Parameters:
FIFO_WIDTH, 3, log2 of FIFO depth (DEPTH = 2^FIFO_WIDTH = 8 entries)
FULL_SLACK, 2, free entries reserved so writes already in flight when io_buffer_full rises are still accepted

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, asynchronous, active-high
rdy_in  input  1  cpu ready; when low, bus decode is disabled
mem_a  input  32  cpu address bus; only [17:0] is decoded
mem_dout  input  8  cpu write data byte
mem_wr  input  1  1 = write
io_buffer_full  output  1  back-pressure to cpu
tx_data  output  8  byte offered to UART
tx_valid  output  1  tx_data is valid
tx_ready  input  1  UART accepts the byte this cycle
program_stop  output  1  one-cycle pulse: program has ended and all output has drained
overflow  output  1  sticky; a byte was dropped because the FIFO was full

Behaviour:
- Clock and reset: one clock, clk_in. rst_in is asynchronous and active-high. While rst_in is high: head = 0, tail = 0, count = 0, stop_pending = 0, io_buffer_full = 0, program_stop = 0, overflow = 0. tx_valid is therefore 0. FIFO storage is not reset.
- Decode (push, data byte): push_req = rdy_in & mem_wr & (mem_a[17:16] == 2'b11) & (mem_a[2:0] == 3'b000) & (mem_dout != 8'h00).
  - A write of 0x00 to 0x30000 is ignored.
  - Reads are ignored.
- Decode (stop): stop_req = rdy_in & mem_wr & (mem_a[17:16] == 2'b11) & (mem_a[2:0] == 3'b100).
- FIFO: first-word-fall-through.
  - tx_valid = (count != 0) and tx_data = mem[head], both driven directly from registers.
  - pop = tx_valid & tx_ready. On pop, head increments modulo DEPTH.
  - On an accepted push, the byte is written to mem[tail] and tail increments modulo DEPTH.
  - Pointers wrap naturally at FIFO_WIDTH bits. count is FIFO_WIDTH+1 bits wide.
- Full FIFO:
  - A push with count == DEPTH and no pop in the same cycle is dropped and sets overflow (sticky until reset).
  - A simultaneous push and pop at count == DEPTH is accepted; count stays at DEPTH.
- Empty FIFO: a push into an empty FIFO makes tx_valid 1 on the next cycle. There is no same-cycle bypass.
- io_buffer_full: registered; equals (count_next >= DEPTH - FULL_SLACK). With the defaults it is asserted at count >= 6, one cycle after the push that reaches 6.
- Stop sequence:
  - stop_req sets stop_pending.
  - While stop_pending = 1, further push_req are discarded. They do not set overflow.
  - When stop_pending = 1 and count == 0 (with no push in the same cycle), program_stop pulses high for exactly one cycle and stop_pending clears.
  - A stop_req with the FIFO already empty produces program_stop on the cycle after stop_req. Latency is exactly 1.
  - A second stop_req while stop_pending is already set has no extra effect.
- rdy_in low: push_req and stop_req are forced to 0. The UART drain (pop) and the stop-sequence completion continue, because the UART runs independently of the cpu.
- Reset mid-operation: queued bytes are lost, no pulse is issued, and stop_pending clears.

Optional Feature:
IO_TX_STATS_EN:
- Defined: adds output tx_byte_cnt [31:0].
  - Reset 0; increments on every pop; wraps at 2^32.
  - Also adds output drop_cnt [15:0], which increments on every dropped push (full FIFO only) and saturates at 16'hFFFF.
- Undefined: neither port nor its counters exist; all other behaviour is identical.

Test Plan:
- Single byte: write 0x41 to 0x30000 with tx_ready = 1 -> tx_valid = 1 and tx_data = 0x41 the next cycle, held for exactly 1 cycle; count returns to 0.
- Zero filter and address decode: write 0x00 to 0x30000, write 0x55 to 0x00100, then read 0x30000 -> tx_valid stays 0 throughout; overflow = 0.
- Back-pressure and overflow: tx_ready = 0, write 0x01..0x09 on consecutive cycles -> io_buffer_full rises the cycle after the 6th write. The 9th byte is dropped and overflow = 1. Then set tx_ready = 1 -> tx_data sequence is 0x01..0x08 and wraps correctly.
- Full with simultaneous pop: fill to 8 entries, then push 0x77 in the same cycle as a pop -> accepted; 0x77 is delivered as the 8th byte after the original 7 remaining.
- Stop drains first: queue 3 bytes with tx_ready = 0, write 0x30004, then push 0x42, then set tx_ready = 1 -> 3 bytes are delivered and 0x42 is never sent. program_stop pulses once, on the cycle after the last pop.
- rdy_in low: hold rdy_in = 0 while driving a write of 0x33 to 0x30000 -> no push occurs. With 2 entries already queued, the drain continues and both bytes are delivered.
